// File: rtl/itcm_arb_pkg.sv
// itcm_arb_pkg: shared defaults and types for the instruction-TCM arbiter.
//   PC_SIZE / XLEN_DEF  : default request address and data widths
//   ITCM_AW_DEF         : default TCM word-address width (4096 words)
//   ITCM_BASE_DEF       : default byte base of the TCM window
//   STARVE_MAX_DEF      : default LSU wait limit before it is forced to win
//   arb_state_e         : arbiter priority state
package itcm_arb_pkg;

  localparam int          PC_SIZE        = 32;
  localparam int          XLEN_DEF       = 32;
  localparam int          ITCM_AW_DEF    = 12;
  localparam logic [31:0] ITCM_BASE_DEF  = 32'h0000_0000;
  localparam int          STARVE_MAX_DEF = 4;

  typedef enum logic {
    IFU_PRI   = 1'b0,
    LSU_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/itcm_arb_if.sv
// itcm_arb_if: one requester channel of the TCM arbiter.
//   req_valid/req_ready/req_addr : read request handshake (byte address)
//   rsp_valid/rsp_ready          : registered response handshake
//   rsp_data/rsp_err             : read word and out-of-window flag
// master = requester side (IFU or LSU), slave = arbiter side.
interface itcm_arb_if
  import itcm_arb_pkg::*;
#(
  parameter int PC_W = PC_SIZE,
  parameter int XLEN = XLEN_DEF
);
  logic            req_valid;
  logic            req_ready;
  logic [PC_W-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/itcm_rsp_slot.sv
// itcm_rsp_slot: one-entry registered response buffer.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture load_data/load_err and raise rsp_valid
//   flush           : drop the held response (wins over drain)
//   rsp_ready       : consumer takes the response this cycle
//   rsp_valid/data/err : held response
//   free            : slot can accept a load this cycle (empty or draining)
module itcm_rsp_slot #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_err,
  input  logic            rsp_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic            free
);

  assign free = !rsp_valid || rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (flush)          rsp_valid <= 1'b0;
      else if (load)      rsp_valid <= 1'b1;
      else if (rsp_ready) rsp_valid <= 1'b0;
      // Data only changes on a load, so it is stable while waiting for rsp_ready.
      if (load) begin
        rsp_data <= load_data;
        rsp_err  <= load_err;
      end
    end
  end

endmodule

// File: rtl/itcm_arb.sv
// itcm_arb: shares the single-port combinational-read ITCM between the IFU
// fetch path and an LSU read path.
//   clk, rst   : core clock, asynchronous active-high reset
//   ifu        : IFU request/response channel (slave modport)
//   ifu_flush  : drop pending IFU response, block IFU accept this cycle
//   lsu        : LSU request/response channel (slave modport)
//   itcm_addr  : TCM word address
//   itcm_rdata : TCM read data, combinational from itcm_addr
// IFU has priority; an LSU request that waits STARVE_MAX cycles is forced through.
module itcm_arb
  import itcm_arb_pkg::*;
#(
  parameter int              PC_W       = PC_SIZE,
  parameter int              XLEN       = XLEN_DEF,
  parameter int              ITCM_AW    = ITCM_AW_DEF,
  parameter logic [PC_W-1:0] ITCM_BASE  = PC_W'(ITCM_BASE_DEF),
  parameter int              STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  itcm_arb_if.slave          ifu,
  input  logic               ifu_flush,
  itcm_arb_if.slave          lsu,
  output logic [ITCM_AW-1:0] itcm_addr,
  input  logic [XLEN-1:0]    itcm_rdata
);

  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [PC_W:0] WIN_BYTES  = (PC_W+1)'(1) << (ITCM_AW + 2);

  // Window check as an offset from the base at PC_W+2 bits: the top bit is the
  // borrow (address below base), and the upper bound cannot wrap.
  function automatic logic in_window(input logic [PC_W-1:0] a);
    logic [PC_W+1:0] off;
    off = {2'b00, a} - {2'b00, ITCM_BASE};
    return !off[PC_W+1] && (off[PC_W:0] < WIN_BYTES);
  endfunction

  arb_state_e      state_q, state_d;
  logic [3:0]      starve_cnt, cnt_d;
  logic            free_ifu, free_lsu;
  logic            ifu_ready, lsu_ready;
  logic            acc_ifu, acc_lsu;
  logic [PC_W-1:0] sel_addr;
  logic            sel_ok;
  logic [XLEN-1:0] cap_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IFU_PRI;
      starve_cnt <= 4'd0;
    end else begin
      state_q    <= state_d;
      starve_cnt <= cnt_d;
    end
  end

  always_comb begin
    ifu_ready = 1'b0;
    lsu_ready = 1'b0;
    state_d   = state_q;
    cnt_d     = starve_cnt;
    case (state_q)
      IFU_PRI: begin
        ifu_ready = free_ifu && !ifu_flush;
        lsu_ready = free_lsu && !(ifu.req_valid && ifu_ready);
      end
      LSU_FORCE: begin
        lsu_ready = free_lsu;
        ifu_ready = free_ifu && !ifu_flush && !lsu.req_valid;
      end
    endcase
    acc_ifu = ifu.req_valid && ifu_ready;
    acc_lsu = lsu.req_valid && lsu_ready;

    if (!lsu.req_valid || acc_lsu)  cnt_d = 4'd0;
    else if (starve_cnt != STARVE_LIM) cnt_d = starve_cnt + 4'd1;

    // Switching on the updated count makes the LSU win in the cycle right
    // after its STARVE_MAX-th lost cycle.
    case (state_q)
      IFU_PRI:   if (cnt_d == STARVE_LIM) state_d = LSU_FORCE;
      LSU_FORCE: if (acc_lsu || !lsu.req_valid) state_d = IFU_PRI;
    endcase
  end

  assign ifu.req_ready = ifu_ready;
  assign lsu.req_ready = lsu_ready;

  assign sel_addr  = acc_lsu ? lsu.req_addr : ifu.req_addr;
  assign itcm_addr = sel_addr[ITCM_AW+1:2];
  assign sel_ok    = in_window(sel_addr);
  assign cap_data  = sel_ok ? itcm_rdata : '0;

  itcm_rsp_slot #(.XLEN(XLEN)) u_ifu_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (acc_ifu),
    .flush     (ifu_flush),
    .load_data (cap_data),
    .load_err  (!sel_ok),
    .rsp_ready (ifu.rsp_ready),
    .rsp_valid (ifu.rsp_valid),
    .rsp_data  (ifu.rsp_data),
    .rsp_err   (ifu.rsp_err),
    .free      (free_ifu)
  );

  itcm_rsp_slot #(.XLEN(XLEN)) u_lsu_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (acc_lsu),
    .flush     (1'b0),
    .load_data (cap_data),
    .load_err  (!sel_ok),
    .rsp_ready (lsu.rsp_ready),
    .rsp_valid (lsu.rsp_valid),
    .rsp_data  (lsu.rsp_data),
    .rsp_err   (lsu.rsp_err),
    .free      (free_lsu)
  );

endmodule

// File: tb/tb_itcm_arb.sv
// tb_itcm_arb: directed scenarios plus a randomized run against a
// behavioural model of the arbiter (wait-count priority, response slots).
module tb_itcm_arb;

  localparam int SMAX = 4;

  logic        clk;
  logic        rst;
  logic        ifu_flush;
  logic [11:0] itcm_addr;
  logic [31:0] itcm_rdata;
  logic [31:0] mem [0:4095];

  int n_chk  = 0;
  int n_pass = 0;

  itcm_arb_if #(.PC_W(32), .XLEN(32)) ifu_if ();
  itcm_arb_if #(.PC_W(32), .XLEN(32)) lsu_if ();

  itcm_arb #(.STARVE_MAX(SMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu        (ifu_if),
    .ifu_flush  (ifu_flush),
    .lsu        (lsu_if),
    .itcm_addr  (itcm_addr),
    .itcm_rdata (itcm_rdata)
  );

  assign itcm_rdata = mem[itcm_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifu_if.req_valid = 1'b0; ifu_if.req_addr = '0; ifu_if.rsp_ready = 1'b1;
    lsu_if.req_valid = 1'b0; lsu_if.req_addr = '0; lsu_if.rsp_ready = 1'b1;
    ifu_flush = 1'b0;
    nxt(); nxt();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if ({ifu_if.rsp_valid, lsu_if.rsp_valid} !== 2'b00) $display("FAIL reset_valid: got %b want 00", {ifu_if.rsp_valid, lsu_if.rsp_valid}); else n_pass++;
    n_chk++; if ({ifu_if.rsp_data, lsu_if.rsp_data, ifu_if.rsp_err, lsu_if.rsp_err} !== 66'd0) $display("FAIL reset_data: got %h/%h err %b%b want 0", ifu_if.rsp_data, lsu_if.rsp_data, ifu_if.rsp_err, lsu_if.rsp_err); else n_pass++;
    n_chk++; if ({ifu_if.req_ready, lsu_if.req_ready} !== 2'b11) $display("FAIL reset_ready: got %b want 11", {ifu_if.req_ready, lsu_if.req_ready}); else n_pass++;
    n_chk++; if (dut.starve_cnt !== 4'd0) $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt); else n_pass++;
    nxt();
  endtask

  task automatic test_ifu_stream();
    ifu_if.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifu_if.req_valid = 1'b1;
      ifu_if.req_addr  = 32'(i * 4);
      @(negedge clk);
      n_chk++; if (ifu_if.req_ready !== 1'b1) $display("FAIL stream_ready%0d: got %b want 1", i, ifu_if.req_ready); else n_pass++;
      n_chk++; if (itcm_addr !== 12'(i)) $display("FAIL stream_addr%0d: got %0d want %0d", i, itcm_addr, i); else n_pass++;
      if (i > 0) begin
        n_chk++; if (ifu_if.rsp_valid !== 1'b1 || ifu_if.rsp_data !== mem[i-1]) $display("FAIL stream_rsp%0d: got v=%b %h want v=1 %h", i, ifu_if.rsp_valid, ifu_if.rsp_data, mem[i-1]); else n_pass++;
      end
      nxt();
    end
    ifu_if.req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (ifu_if.rsp_valid !== 1'b1 || ifu_if.rsp_data !== mem[2]) $display("FAIL stream_rsp3: got v=%b %h want v=1 %h", ifu_if.rsp_valid, ifu_if.rsp_data, mem[2]); else n_pass++;
    nxt();
    @(negedge clk);
    n_chk++; if (ifu_if.rsp_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", ifu_if.rsp_valid); else n_pass++;
    idle();
  endtask

  task automatic test_starvation();
    ifu_if.req_valid = 1'b1; ifu_if.req_addr = 32'h40;
    lsu_if.req_valid = 1'b1; lsu_if.req_addr = 32'h100;
    for (int c = 1; c <= SMAX; c++) begin
      @(negedge clk);
      n_chk++; if ({ifu_if.req_ready, lsu_if.req_ready} !== 2'b10) $display("FAIL starve_c%0d: got ifu/lsu ready %b want 10", c, {ifu_if.req_ready, lsu_if.req_ready}); else n_pass++;
      nxt();
    end
    @(negedge clk);
    n_chk++; if ({ifu_if.req_ready, lsu_if.req_ready} !== 2'b01) $display("FAIL starve_force: got ifu/lsu ready %b want 01", {ifu_if.req_ready, lsu_if.req_ready}); else n_pass++;
    n_chk++; if (itcm_addr !== 12'h040) $display("FAIL starve_addr: got %h want 040", itcm_addr); else n_pass++;
    n_chk++; if (dut.starve_cnt !== 4'(SMAX)) $display("FAIL starve_cnt: got %0d want %0d", dut.starve_cnt, SMAX); else n_pass++;
    nxt();
    lsu_if.req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (ifu_if.req_ready !== 1'b1 || itcm_addr !== 12'h010) $display("FAIL starve_resume: got ready %b addr %h want 1 010", ifu_if.req_ready, itcm_addr); else n_pass++;
    n_chk++; if (lsu_if.rsp_valid !== 1'b1 || lsu_if.rsp_data !== mem[12'h040]) $display("FAIL starve_lsu_rsp: got v=%b %h want v=1 %h", lsu_if.rsp_valid, lsu_if.rsp_data, mem[12'h040]); else n_pass++;
    idle();
  endtask

  task automatic test_out_of_range();
    lsu_if.req_valid = 1'b1; lsu_if.req_addr = 32'h3FFC;
    @(negedge clk);
    n_chk++; if (lsu_if.req_ready !== 1'b1 || itcm_addr !== 12'hFFF) $display("FAIL oor_last_acc: got ready %b addr %h want 1 fff", lsu_if.req_ready, itcm_addr); else n_pass++;
    nxt();
    lsu_if.req_addr = 32'h4000;
    @(negedge clk);
    n_chk++; if ({lsu_if.rsp_valid, lsu_if.rsp_err} !== 2'b10 || lsu_if.rsp_data !== mem[4095]) $display("FAIL oor_last_rsp: got v=%b e=%b %h want v=1 e=0 %h", lsu_if.rsp_valid, lsu_if.rsp_err, lsu_if.rsp_data, mem[4095]); else n_pass++;
    n_chk++; if (lsu_if.req_ready !== 1'b1) $display("FAIL oor_acc: got %b want 1", lsu_if.req_ready); else n_pass++;
    nxt();
    lsu_if.req_valid = 1'b0;
    ifu_if.req_valid = 1'b1; ifu_if.req_addr = 32'h10;
    @(negedge clk);
    n_chk++; if ({lsu_if.rsp_valid, lsu_if.rsp_err} !== 2'b11 || lsu_if.rsp_data !== 32'h0) $display("FAIL oor_rsp: got v=%b e=%b %h want v=1 e=1 0", lsu_if.rsp_valid, lsu_if.rsp_err, lsu_if.rsp_data); else n_pass++;
    n_chk++; if (ifu_if.req_ready !== 1'b1 || itcm_addr !== 12'h004) $display("FAIL oor_ifu_acc: got ready %b addr %h want 1 004", ifu_if.req_ready, itcm_addr); else n_pass++;
    nxt();
    ifu_if.req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if ({ifu_if.rsp_valid, ifu_if.rsp_err} !== 2'b10 || ifu_if.rsp_data !== mem[4]) $display("FAIL oor_ifu_rsp: got v=%b e=%b %h want v=1 e=0 %h", ifu_if.rsp_valid, ifu_if.rsp_err, ifu_if.rsp_data, mem[4]); else n_pass++;
    idle();
  endtask

  task automatic test_flush();
    ifu_if.rsp_ready = 1'b0;
    ifu_if.req_valid = 1'b1; ifu_if.req_addr = 32'h20;
    nxt();
    ifu_if.req_addr = 32'h24;
    ifu_flush = 1'b1;
    lsu_if.req_valid = 1'b1; lsu_if.req_addr = 32'h50;
    @(negedge clk);
    n_chk++; if (ifu_if.rsp_valid !== 1'b1 || ifu_if.rsp_data !== mem[8]) $display("FAIL flush_pending: got v=%b %h want v=1 %h", ifu_if.rsp_valid, ifu_if.rsp_data, mem[8]); else n_pass++;
    n_chk++; if ({ifu_if.req_ready, lsu_if.req_ready} !== 2'b01) $display("FAIL flush_ready: got ifu/lsu %b want 01", {ifu_if.req_ready, lsu_if.req_ready}); else n_pass++;
    nxt();
    ifu_flush = 1'b0;
    lsu_if.req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (ifu_if.rsp_valid !== 1'b0) $display("FAIL flush_drop: got %b want 0", ifu_if.rsp_valid); else n_pass++;
    n_chk++; if (lsu_if.rsp_valid !== 1'b1 || lsu_if.rsp_data !== mem[20]) $display("FAIL flush_lsu: got v=%b %h want v=1 %h", lsu_if.rsp_valid, lsu_if.rsp_data, mem[20]); else n_pass++;
    n_chk++; if (ifu_if.req_ready !== 1'b1 || itcm_addr !== 12'h009) $display("FAIL flush_reacc: got ready %b addr %h want 1 009", ifu_if.req_ready, itcm_addr); else n_pass++;
    nxt();
    ifu_if.req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (ifu_if.rsp_valid !== 1'b1 || ifu_if.rsp_data !== mem[9]) $display("FAIL flush_next: got v=%b %h want v=1 %h", ifu_if.rsp_valid, ifu_if.rsp_data, mem[9]); else n_pass++;
    ifu_flush = 1'b1;
    ifu_if.rsp_ready = 1'b1;
    nxt();
    ifu_flush = 1'b0;
    @(negedge clk);
    n_chk++; if (ifu_if.rsp_valid !== 1'b0) $display("FAIL flush_with_ready: got %b want 0", ifu_if.rsp_valid); else n_pass++;
    idle();
  endtask

  task automatic test_back_to_back();
    lsu_if.rsp_ready = 1'b0;
    lsu_if.req_valid = 1'b1; lsu_if.req_addr = 32'h80;
    nxt();
    lsu_if.req_addr = 32'h84;
    @(negedge clk);
    n_chk++; if (lsu_if.rsp_valid !== 1'b1 || lsu_if.rsp_data !== mem[32]) $display("FAIL b2b_first: got v=%b %h want v=1 %h", lsu_if.rsp_valid, lsu_if.rsp_data, mem[32]); else n_pass++;
    n_chk++; if (lsu_if.req_ready !== 1'b0) $display("FAIL b2b_full: got %b want 0", lsu_if.req_ready); else n_pass++;
    nxt();
    lsu_if.rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (lsu_if.req_ready !== 1'b1 || itcm_addr !== 12'h021) $display("FAIL b2b_reload: got ready %b addr %h want 1 021", lsu_if.req_ready, itcm_addr); else n_pass++;
    nxt();
    lsu_if.req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (lsu_if.rsp_valid !== 1'b1 || lsu_if.rsp_data !== mem[33]) $display("FAIL b2b_second: got v=%b %h want v=1 %h", lsu_if.rsp_valid, lsu_if.rsp_data, mem[33]); else n_pass++;
    idle();
  endtask

  task automatic test_async_reset();
    ifu_if.rsp_ready = 1'b0; lsu_if.rsp_ready = 1'b0;
    ifu_if.req_valid = 1'b1; ifu_if.req_addr = 32'h30;
    nxt();
    ifu_if.req_valid = 1'b0;
    lsu_if.req_valid = 1'b1; lsu_if.req_addr = 32'h40;
    nxt();
    lsu_if.req_addr = 32'h44;
    nxt();
    @(negedge clk);
    n_chk++; if ({ifu_if.rsp_valid, lsu_if.rsp_valid} !== 2'b11 || dut.starve_cnt !== 4'd1) $display("FAIL arst_pre: got v=%b cnt=%0d want 11 1", {ifu_if.rsp_valid, lsu_if.rsp_valid}, dut.starve_cnt); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_chk++; if ({ifu_if.rsp_valid, lsu_if.rsp_valid, ifu_if.rsp_err, lsu_if.rsp_err} !== 4'b0000 || {ifu_if.rsp_data, lsu_if.rsp_data} !== 64'd0) $display("FAIL arst_clear: got v=%b e=%b %h/%h want all 0", {ifu_if.rsp_valid, lsu_if.rsp_valid}, {ifu_if.rsp_err, lsu_if.rsp_err}, ifu_if.rsp_data, lsu_if.rsp_data); else n_pass++;
    n_chk++; if (dut.starve_cnt !== 4'd0) $display("FAIL arst_cnt: got %0d want 0", dut.starve_cnt); else n_pass++;
    lsu_if.req_valid = 1'b0;
    ifu_if.rsp_ready = 1'b1; lsu_if.rsp_ready = 1'b1;
    nxt();
    rst = 1'b0;
    ifu_if.req_valid = 1'b1; ifu_if.req_addr = 32'h30;
    @(negedge clk);
    n_chk++; if (ifu_if.req_ready !== 1'b1) $display("FAIL arst_after_acc: got %b want 1", ifu_if.req_ready); else n_pass++;
    nxt();
    ifu_if.req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (ifu_if.rsp_valid !== 1'b1 || ifu_if.rsp_data !== mem[12]) $display("FAIL arst_after_rsp: got v=%b %h want v=1 %h", ifu_if.rsp_valid, ifu_if.rsp_data, mem[12]); else n_pass++;
    idle();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 32'h4000 + 32'($urandom_range(0, 255) * 4);
    if (r == 1) return $urandom | 32'h8000_0000;
    return {18'd0, 12'($urandom), 2'($urandom)};
  endfunction

  // Model: the LSU wins once it has lost STARVE_MAX consecutive cycles;
  // each requester owns a one-deep response buffer.
  task automatic test_random();
    logic        e_iv, e_ie, e_lv, e_le;
    logic [31:0] e_id, e_ld;
    logic        fi, fl, ir, lr, ai, al, ok;
    logic [31:0] a;
    logic [11:0] ea;
    int          waited;
    rst = 1'b1; nxt(); rst = 1'b0;
    e_iv = 0; e_ie = 0; e_lv = 0; e_le = 0; e_id = 0; e_ld = 0; waited = 0;
    for (int c = 0; c < 3000; c++) begin
      ifu_if.req_valid = ($urandom_range(0, 9) < 7);
      ifu_if.req_addr  = rand_addr();
      ifu_if.rsp_ready = ($urandom_range(0, 3) != 0);
      lsu_if.req_valid = ($urandom_range(0, 9) < 5);
      lsu_if.req_addr  = rand_addr();
      lsu_if.rsp_ready = ($urandom_range(0, 3) != 0);
      ifu_flush        = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      fi = !e_iv || ifu_if.rsp_ready;
      fl = !e_lv || lsu_if.rsp_ready;
      if (waited >= SMAX) begin
        lr = fl;
        ir = fi && !ifu_flush && !lsu_if.req_valid;
      end else begin
        ir = fi && !ifu_flush;
        lr = fl && !(ifu_if.req_valid && ir);
      end
      ai = ifu_if.req_valid && ir;
      al = lsu_if.req_valid && lr;
      a  = al ? lsu_if.req_addr : ifu_if.req_addr;
      ea = a[13:2];
      ok = (a < 32'h4000);
      n_chk++; if ({ifu_if.req_ready, lsu_if.req_ready} !== {ir, lr}) $display("FAIL rnd_ready c%0d: got %b want %b", c, {ifu_if.req_ready, lsu_if.req_ready}, {ir, lr}); else n_pass++;
      n_chk++; if (itcm_addr !== ea) $display("FAIL rnd_addr c%0d: got %h want %h", c, itcm_addr, ea); else n_pass++;
      n_chk++; if (ifu_if.rsp_valid !== e_iv || (e_iv && {ifu_if.rsp_data, ifu_if.rsp_err} !== {e_id, e_ie})) $display("FAIL rnd_ifu_rsp c%0d: got v=%b %h e=%b want v=%b %h e=%b", c, ifu_if.rsp_valid, ifu_if.rsp_data, ifu_if.rsp_err, e_iv, e_id, e_ie); else n_pass++;
      n_chk++; if (lsu_if.rsp_valid !== e_lv || (e_lv && {lsu_if.rsp_data, lsu_if.rsp_err} !== {e_ld, e_le})) $display("FAIL rnd_lsu_rsp c%0d: got v=%b %h e=%b want v=%b %h e=%b", c, lsu_if.rsp_valid, lsu_if.rsp_data, lsu_if.rsp_err, e_lv, e_ld, e_le); else n_pass++;
      if (ifu_flush)             e_iv = 1'b0;
      else if (ai) begin         e_iv = 1'b1; e_id = ok ? mem[ea] : 32'h0; e_ie = !ok; end
      else if (ifu_if.rsp_ready) e_iv = 1'b0;
      if (al) begin              e_lv = 1'b1; e_ld = ok ? mem[ea] : 32'h0; e_le = !ok; end
      else if (lsu_if.rsp_ready) e_lv = 1'b0;
      if (!lsu_if.req_valid || al) waited = 0;
      else                         waited++;
      nxt();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    rst = 1'b1;
    ifu_flush = 1'b0;
    ifu_if.req_valid = 1'b0; ifu_if.req_addr = '0; ifu_if.rsp_ready = 1'b1;
    lsu_if.req_valid = 1'b0; lsu_if.req_addr = '0; lsu_if.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_ifu_stream();
    test_starvation();
    test_out_of_range();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/itcm_arb.md
Name: itcm_arb

Overview:
- Arbiter and sequencer for the single-port, combinational-read instruction TCM (4K-word OTP).
- Shares the TCM between the IFU fetch path and an LSU read path (constant tables, load-from-code).
- Each requester has a valid/ready request channel and a one-entry registered response channel.
- Sits between the IFU, the LSU and the TCM macro. It replaces the direct IFU-to-TCM address connection.

Parameters:
- PC_W, 32, request address width (matches the core PC width)
- XLEN, 32, TCM data width
- ITCM_AW, 12, TCM word-address width (4096 words)
- ITCM_BASE, 32'h0000_0000, byte base address of the TCM window
- STARVE_MAX, 4, LSU wait-cycle limit before the LSU is forced to win (range 1..15)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted
- ifu_req_addr  in  PC_W  IFU byte address
- ifu_rsp_valid  out  1  IFU response available
- ifu_rsp_ready  in  1  IFU consumes the response
- ifu_rsp_data  out  XLEN  fetched word
- ifu_rsp_err  out  1  address was outside the TCM window
- ifu_flush  in  1  pipe flush: drop the pending IFU response and block IFU accept
- lsu_req_valid  in  1  LSU read request
- lsu_req_ready  out  1  LSU request accepted
- lsu_req_addr  in  PC_W  LSU byte address
- lsu_rsp_valid  out  1  LSU response available
- lsu_rsp_ready  in  1  LSU consumes the response
- lsu_rsp_data  out  XLEN  read word
- lsu_rsp_err  out  1  address was outside the TCM window
- itcm_addr  out  ITCM_AW  TCM word address (drives the macro address input)
- itcm_rdata  in  XLEN  TCM read data (combinational from itcm_addr)

Behaviour:
- Reset values: ifu_rsp_valid, lsu_rsp_valid, both rsp_data, both rsp_err and starve_cnt all 0. Arbiter state = IFU_PRI.
- Ready signals are combinational from state, so after reset ifu_req_ready=1 while ifu_flush=0.
- Slot free: a slot is free when rsp_valid=0, or when rsp_valid&&rsp_ready in the same cycle (pass-through drain).
- Arbiter state IFU_PRI:
  - ifu_req_ready = slot_free_ifu && !ifu_flush.
  - lsu_req_ready = slot_free_lsu && !(ifu_req_valid && ifu_req_ready).
- Arbiter state LSU_FORCE:
  - lsu_req_ready = slot_free_lsu.
  - ifu_req_ready = slot_free_ifu && !ifu_flush && !lsu_req_valid.
- State transitions:
  - IFU_PRI -> LSU_FORCE when starve_cnt==STARVE_MAX.
  - LSU_FORCE -> IFU_PRI on LSU accept, or when lsu_req_valid drops.
- Starvation counter (4-bit, saturating at STARVE_MAX):
  - +1 each cycle lsu_req_valid && !lsu_req_ready.
  - Cleared on LSU accept or when lsu_req_valid=0.
- At most one accept per cycle; this is guaranteed by the ready equations.
- itcm_addr mux: selects the LSU address if lsu_req_valid && lsu_req_ready, else the IFU address. The value is addr[ITCM_AW+1:2]; addr[1:0] is ignored.
- Range check: a request is in range iff ITCM_BASE <= addr < ITCM_BASE + 4*2^ITCM_AW, computed at PC_W+1 bits so the upper bound does not wrap.
  - Out-of-range accept: captures data 0 and err=1, and still completes a response.
- Latency: accept in cycle N -> itcm_rdata is captured at the end of N -> rsp_valid=1 in N+1.
  - Response data and err are held stable until rsp_ready.
  - Back-to-back throughput of one request per cycle per requester, provided rsp_ready stays high.
- Flush:
  - ifu_flush=1 in cycle N clears ifu_rsp_valid at the end of N. This applies even when ifu_rsp_ready=1 in the same cycle (flush wins; the consumer discards).
  - No IFU accept happens in cycle N.
  - An LSU accept in cycle N is unaffected.
- Simultaneous events:
  - LSU response drain and new LSU accept in the same cycle: the slot reloads; rsp_valid stays 1.
  - Reset asserted mid-transfer: responses are lost and all outputs return to reset values immediately (asynchronous).
- The block issues no TCM writes and has no multi-cycle states beyond the arbiter state and the counter.

Decomposition:
- mcu_defines holds PC_SIZE, XLEN, ITCM_BASE and ITCM_AW defaults.
- Arbiter state encodings (IFU_PRI=1'b0, LSU_FORCE=1'b1) are defined as local constants.
- One sub-module, itcm_rsp_slot: a one-entry response register with valid/ready, load, flush and err capture. It is instantiated twice (IFU, LSU).

Test Plan:
1. Reset, then IFU requests 0x0000_0000, 0x04, 0x08 with rsp_ready=1 -> itcm_addr=0,1,2 in consecutive cycles; rsp_valid in cycles 1..3 with matching words; ready stays 1.
2. IFU and LSU both valid with STARVE_MAX=4 -> IFU wins 4 cycles, starve_cnt reaches 4, LSU accepted in the 5th cycle with ifu_req_ready=0; IFU resumes next cycle.
3. LSU addr 0x0000_4000 (just past the window) -> lsu_rsp_valid one cycle later, lsu_rsp_err=1, lsu_rsp_data=0; the IFU stream is unaffected.
4. IFU response pending with ifu_rsp_ready=0, then ifu_flush pulse -> ifu_rsp_valid=0 next cycle; no IFU accept during the flush cycle; next IFU request returns correct data.
5. lsu_rsp_ready held 0 -> lsu_req_ready=0 after one accept; raising rsp_ready together with a new request -> drain and reload in the same cycle, lsu_rsp_valid continuous.
6. Assert rst mid-stream with both responses valid -> all rsp_valid/err/data go to 0 asynchronously and starve_cnt=0; normal operation after deassert.
